// File: rtl/serializer_stream.sv
// serializer_stream: gapless word-to-bit serializer with one-word holding buffer
module serializer_stream #(
  parameter int DATA_W = 16,
  parameter int MIN_LEN = 3,
  localparam int MOD_W = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_msb_first_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  output logic              busy_o
);
  logic [DATA_W-1:0] act_sr, buf_data;
  logic [MOD_W:0]    act_cnt, buf_len, in_len;
  logic              act_msb, act_val, buf_msb, buf_full;
  logic              acc_ok, act_free;
  // Decode the length field (0 = full word) and qualify the handshake; short words are swallowed here
  always_comb begin
    in_len = (data_mod_i == '0) ? (MOD_W+1)'(DATA_W) : {1'b0, data_mod_i};
    acc_ok = data_val_i & ~buf_full & (in_len >= (MOD_W+1)'(MIN_LEN));
    ser_last_o = act_val & (act_cnt == (MOD_W+1)'(1));
    act_free = ~act_val | ser_last_o;
    ser_data_o = act_val & (act_msb ? act_sr[DATA_W-1] : act_sr[0]);
    ser_data_val_o = act_val;
    busy_o = act_val | buf_full;
    data_rdy_o = ~buf_full;
  end
  // Active stage: reload from buffer (priority) or bypass on the last bit, otherwise shift out
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      act_sr <= '0;
      act_cnt <= '0;
      act_msb <= 1'b0;
      act_val <= 1'b0;
    end else if (act_free) begin
      act_val <= buf_full | acc_ok;
      act_sr <= buf_full ? buf_data : data_i;
      act_cnt <= buf_full ? buf_len : in_len;
      act_msb <= buf_full ? buf_msb : data_msb_first_i;
    end else begin
      act_sr <= act_msb ? {act_sr[DATA_W-2:0], 1'b0} : {1'b0, act_sr[DATA_W-1:1]};
      act_cnt <= act_cnt - 1'b1;
    end
  // Holding buffer: filled only while the active stage is busy, drained whenever it frees up
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      buf_data <= '0;
      buf_len <= '0;
      buf_msb <= 1'b0;
      buf_full <= 1'b0;
    end else begin
      buf_full <= ~act_free & (buf_full | acc_ok);
      if (acc_ok & ~act_free) begin
        buf_data <= data_i;
        buf_len <= in_len;
        buf_msb <= data_msb_first_i;
      end
    end
endmodule

// File: tb/tb_serializer_stream.sv
// tb_serializer_stream: directed checks of the serializer at 16 and 32 bit widths
module tb_serializer_stream;
  logic clk_i = 1'b0;
  logic arst_n_i = 1'b0;
  logic [15:0] a_data = '0;
  logic [3:0]  a_mod = '0;
  logic        a_msb = 1'b0, a_val = 1'b0;
  logic        a_rdy, a_ser, a_sval, a_last, a_busy;
  logic [31:0] b_data = '0;
  logic [4:0]  b_mod = '0;
  logic        b_msb = 1'b0, b_val = 1'b0;
  logic        b_rdy, b_ser, b_sval, b_last, b_busy;
  logic        sel = 1'b0;
  logic        o_rdy, o_ser, o_sval, o_last, o_busy;
  logic [63:0] bits, vals, lasts, rdys;
  int tests = 0, fails = 0;
  always #5 clk_i = ~clk_i;
  assign o_rdy = sel ? b_rdy : a_rdy;
  assign o_ser = sel ? b_ser : a_ser;
  assign o_sval = sel ? b_sval : a_sval;
  assign o_last = sel ? b_last : a_last;
  assign o_busy = sel ? b_busy : a_busy;
  serializer_stream #(.DATA_W(16), .MIN_LEN(3)) dut_a (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(a_data), .data_mod_i(a_mod),
    .data_msb_first_i(a_msb), .data_val_i(a_val), .data_rdy_o(a_rdy), .ser_data_o(a_ser),
    .ser_data_val_o(a_sval), .ser_last_o(a_last), .busy_o(a_busy));
  serializer_stream #(.DATA_W(32), .MIN_LEN(2)) dut_b (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .data_i(b_data), .data_mod_i(b_mod),
    .data_msb_first_i(b_msb), .data_val_i(b_val), .data_rdy_o(b_rdy), .ser_data_o(b_ser),
    .ser_data_val_o(b_sval), .ser_last_o(b_last), .busy_o(b_busy));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [31:0] d, input logic [4:0] mod, input logic msb, input bit keep);
    int n = 0;
    if (sel) begin b_data = d; b_mod = mod; b_msb = msb; b_val = 1'b1; end
    else begin a_data = d[15:0]; a_mod = mod[3:0]; a_msb = msb; a_val = 1'b1; end
    while (!o_rdy && n < 200) begin @(negedge clk_i); n++; end
    if (n >= 200) chk("rdy_timeout", 64'(o_rdy), 64'd1);
    @(posedge clk_i); #1;
    if (!keep) begin a_val = 1'b0; b_val = 1'b0; end
  endtask
  task automatic capture(input int n);
    bits = '0; vals = '0; lasts = '0; rdys = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      bits = {bits[62:0], o_ser};
      vals = {vals[62:0], o_sval};
      lasts = {lasts[62:0], o_last};
      rdys = {rdys[62:0], o_rdy};
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    chk("reset_outs", 64'({a_ser, a_sval, a_last, a_busy, a_rdy}), 64'b00001);
    chk("reset_outs_b", 64'({b_ser, b_sval, b_last, b_busy, b_rdy}), 64'b00001);
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    @(negedge clk_i);
    chk("idle_outs", 64'({a_ser, a_sval, a_last, a_busy, a_rdy}), 64'b00001);
    push(32'hA5C3, 5'd0, 1'b1, 1'b0);
    capture(17);
    chk("a5c3_bits", bits, 64'({16'hA5C3, 1'b0}));
    chk("a5c3_vals", vals, 64'({16'hFFFF, 1'b0}));
    chk("a5c3_last", lasts, 64'b10);
    chk("a5c3_busy", 64'(o_busy), 64'd0);
    push(32'h00B6, 5'd5, 1'b0, 1'b0);
    capture(6);
    chk("b6_bits", bits, 64'b011010);
    chk("b6_vals", vals, 64'b111110);
    chk("b6_last", lasts, 64'b000010);
    chk("b6_busy", 64'(o_busy), 64'd0);
    @(negedge clk_i);
    fork
      begin
        push(32'hA000, 5'd3, 1'b1, 1'b1);
        push(32'h1234, 5'd0, 1'b1, 1'b1);
        push(32'h000C, 5'd4, 1'b0, 1'b1);
        push(32'hFE00, 5'd7, 1'b1, 1'b0);
      end
      capture(31);
    join
    chk("b2b_bits", bits, 64'({3'b101, 16'h1234, 4'b0011, 7'h7F, 1'b0}));
    chk("b2b_vals", vals, 64'({30'h3FFF_FFFF, 1'b0}));
    chk("b2b_last", lasts, 64'h1000_1102);
    chk("b2b_rdy", rdys, 64'({1'b1, 2'b00, 1'b1, 15'd0, 1'b1, 3'b000, 8'hFF}));
    chk("b2b_busy", 64'(o_busy), 64'd0);
    push(32'hE000, 5'd1, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("drop1", 64'({o_sval, o_busy, o_rdy}), 64'b001);
    push(32'hE000, 5'd2, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("drop2", 64'({o_sval, o_busy, o_rdy}), 64'b001);
    push(32'hE000, 5'd3, 1'b1, 1'b0);
    capture(4);
    chk("len3_bits", bits, 64'b1110);
    chk("len3_vals", vals, 64'b1110);
    chk("len3_last", lasts, 64'b0010);
    push(32'hFFFF, 5'd0, 1'b1, 1'b0);
    push(32'hFFFF, 5'd0, 1'b1, 1'b0);
    repeat (4) @(negedge clk_i);
    @(posedge clk_i); #2;
    chk("mid_running", 64'({o_sval, o_busy, o_rdy}), 64'b110);
    arst_n_i = 1'b0;
    #1;
    chk("mid_reset_outs", 64'({o_ser, o_sval, o_last, o_busy, o_rdy}), 64'b00001);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    capture(20);
    chk("post_reset_vals", vals, 64'd0);
    chk("post_reset_bits", bits, 64'd0);
    chk("post_reset_busy", 64'(o_busy), 64'd0);
    sel = 1'b1;
    @(negedge clk_i);
    push(32'h8000_0001, 5'd0, 1'b1, 1'b0);
    capture(33);
    chk("w32_bits", bits, 64'({32'h8000_0001, 1'b0}));
    chk("w32_vals", vals, 64'({32'hFFFF_FFFF, 1'b0}));
    chk("w32_last", lasts, 64'b10);
    push(32'h2, 5'd2, 1'b0, 1'b0);
    capture(3);
    chk("w32_l2_bits", bits, 64'b010);
    chk("w32_l2_vals", vals, 64'b110);
    chk("w32_l2_last", lasts, 64'b010);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
